sweep_sequencer: RTL and testbench
==================================

// Module: sweep_sequencer
// PURPOSE
//  Stimulus sequencer for the 7-switch combinational chain (circuit_a -> circuit_b).
//  Drives the chain's 7-bit input vector either from the board switches (manual) or
//  through an exhaustive sweep 0..2^WIDTH-1, holding each vector for a settle window.
//  After each window it samples the two chain outputs and counts how many vectors
//  drove each output high, giving a truth-table signature for bring-up checks.
// PARAMETERS
//  WIDTH   7   input vector width; sweep covers 2^WIDTH vectors
//  DWELL   4   settle cycles per vector before sampling; must be >= 1
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  start      in   1          sweep request; acted on at its rising edge
//  abort      in   1          level; ends a running sweep
//  manual_en  in   1          when idle, vec follows sw
//  sw         in   WIDTH      switch inputs used in manual mode
//  res        in   2          chain outputs: res[0] = circuit_a Y, res[1] = circuit_b Y
//  vec        out  WIDTH      registered vector driven into the chain
//  busy       out  1          high while a sweep runs (SETTLE or SAMPLE state)
//  done       out  1          level; high in DONE state
//  cnt0       out  WIDTH+1    number of swept vectors with res[0]=1
//  cnt1       out  WIDTH+1    number of swept vectors with res[1]=1
// BEHAVIOUR
//  Reset: state=IDLE; vec, cnt0, cnt1, internal index, dwell counter and start edge reg = 0;
//   busy=0, done=0. Reset takes effect at any time, including mid-sweep.
//  start edge: start_q registered each cycle; edge = start & ~start_q. Edges outside
//   IDLE/DONE are ignored (not queued).
//  States:
//   IDLE   : if manual_en, vec <= sw every cycle (1-cycle latency), else vec holds.
//            On start edge: idx=0, vec<=0, cnt0/cnt1<=0, dwell<=DWELL-1 -> SETTLE.
//   SETTLE : dwell counts down by 1 per cycle; leaves for SAMPLE on the cycle dwell==0.
//            Lasts exactly DWELL cycles.
//   SAMPLE : one cycle; cnt0 += res[0], cnt1 += res[1] (no saturation needed, max 2^WIDTH).
//            If idx == 2^WIDTH-1 -> DONE, vec holds.
//            Else idx++, vec <= idx+1, dwell <= DWELL-1 -> SETTLE.
//   DONE   : done=1; vec holds last vector, counts hold. manual_en behaves as in IDLE.
//            On start edge: same action as from IDLE (done drops next cycle).
//  Timing: each vector occupies DWELL+1 cycles; a full sweep from the start edge to
//   done=1 takes 2^WIDTH*(DWELL+1)+1 cycles.
//  abort: sampled in SETTLE/SAMPLE; takes priority over the SAMPLE update that cycle.
//   Next state is IDLE, vec<=0, counts hold partial values, done stays 0. Ignored in IDLE/DONE.
//  Outputs busy/done are decoded from state (registered state, no combinational input paths).
//  res is sampled only in SAMPLE; any value during SETTLE is ignored.
// TESTING
//  T1 WIDTH=7, DWELL=2, res={vec[6],vec[0]}, start pulse -> done after 385 cycles,
//     cnt0=64, cnt1=64, vec=7'h7F.
//  T2 res=2'b11 held -> cnt0=cnt1=128 (8'h80, no overflow), busy=0 with done=1.
//  T3 idle, manual_en=1, sw=7'h5A -> vec=7'h5A one cycle later; sw=7'h25 -> vec=7'h25.
//  T4 abort asserted while vec=7'h05 -> next cycle state IDLE, vec=0, busy=0, done=0,
//     cnt0/cnt1 hold counts for vectors 0..4 (0..5 if vec 5 already sampled).
//  T5 second start edge mid-sweep -> ignored; sweep completes with T1 counts.
//  T6 reset pulse mid-sweep (vec=7'h40) -> all outputs 0 immediately (async);
//     next start edge runs a clean full sweep with T1 counts.

Source files
------------

// File: rtl/sweep_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_sequencer_if
//  Purpose  : Bundles the control, stimulus and result signals of the sweep
//             sequencer into one interface.
//  Ports    : start, abort, manual_en, sw, res  -> into the sequencer
//             vec, busy, done, cnt0, cnt1      <- out of the sequencer
//  Modports : master - the side that drives the sequencer (board / bench)
//             slave  - the sequencer itself
//  Revision : 1.0  initial release
// ============================================================================
interface sweep_sequencer_if #(
   parameter int WIDTH = 7
);
   logic             start;
   logic             abort;
   logic             manual_en;
   logic [WIDTH-1:0] sw;
   logic [1:0]       res;
   logic [WIDTH-1:0] vec;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   cnt0;
   logic [WIDTH:0]   cnt1;

   modport master (
      output start, abort, manual_en, sw, res,
      input  vec, busy, done, cnt0, cnt1
   );

   modport slave (
      input  start, abort, manual_en, sw, res,
      output vec, busy, done, cnt0, cnt1
   );
endinterface
`default_nettype wire

// File: rtl/sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_sequencer
//  Purpose  : Drives the 7-bit input vector of the circuit_a -> circuit_b chain
//             either from the board switches or through an exhaustive sweep of
//             all 2^WIDTH vectors. Each vector is held for DWELL settle cycles,
//             then the two chain outputs are sampled for one cycle and counted,
//             giving a truth-table signature (cnt0, cnt1) for bring-up.
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous, active-high reset
//             bus   - sweep_sequencer_if.slave
//                     start (edge), abort (level), manual_en, sw, res in;
//                     vec, busy, done, cnt0, cnt1 out (all registered)
//  Revision : 1.0  initial release
// ============================================================================
module sweep_sequencer #(
   parameter int WIDTH = 7,
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              reset,
   sweep_sequencer_if.slave  bus
);

   // Dwell counter only needs to hold DWELL-1.
   localparam int               DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0]    DWELL_INIT = DW'(DWELL - 1);
   localparam logic [WIDTH-1:0] IDX_LAST   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] IDX_ONE    = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] vec_q,   vec_d;
   logic [WIDTH-1:0] idx_q,   idx_d;
   logic [WIDTH:0]   cnt0_q,  cnt0_d;
   logic [WIDTH:0]   cnt1_q,  cnt1_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic             start_q;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             start_edge;

   assign start_edge = bus.start & ~start_q;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      idx_d   = idx_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      dwell_d = dwell_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // A new sweep wins over manual tracking in the same cycle.
            if (start_edge) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               vec_d   = '0;
               cnt0_d  = '0;
               cnt1_d  = '0;
               dwell_d = DWELL_INIT;
            end else if (bus.manual_en) begin
               vec_d = bus.sw;
            end
         end

         S_SETTLE: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               vec_d   = '0;
            end else if (dwell_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               dwell_d = dwell_q - DW'(1);
            end
         end

         S_SAMPLE: begin
            // Abort discards this cycle's sample; counts keep partial totals.
            if (bus.abort) begin
               state_d = S_IDLE;
               vec_d   = '0;
            end else begin
               cnt0_d = cnt0_q + {{WIDTH{1'b0}}, bus.res[0]};
               cnt1_d = cnt1_q + {{WIDTH{1'b0}}, bus.res[1]};
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  vec_d   = idx_q + IDX_ONE;
                  dwell_d = DWELL_INIT;
                  state_d = S_SETTLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Status flags are registered copies of the next-state decode, so they
      // change in the same cycle as the state register.
      busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         idx_q   <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         dwell_q <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         idx_q   <= idx_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         dwell_q <= dwell_d;
         start_q <= bus.start;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.vec  = vec_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.cnt0 = cnt0_q;
   assign bus.cnt1 = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sweep_sequencer
//  Purpose  : Self-checking bench for sweep_sequencer (WIDTH=7, DWELL=2).
//             The chain outputs are emulated by two truth tables indexed by
//             the vector under test; expected counts are sums over the tables.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sweep_sequencer;

   localparam int WIDTH = 7;
   localparam int DWELL = 2;
   localparam int NVEC  = 1 << WIDTH;
   localparam int PER   = DWELL + 1;     // cycles per vector
   localparam int NCYC  = NVEC * PER;    // cycles from edge-taken to done

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sweep_sequencer_if #(.WIDTH(WIDTH)) bus ();

   sweep_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fails  = 0;
   bit tab0 [NVEC];
   bit tab1 [NVEC];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // 0: res = {vec[6], vec[0]}; 1: both outputs stuck high; 2: random tables
   task automatic fill_tables(input int mode);
      for (int v = 0; v < NVEC; v++) begin
         logic [WIDTH-1:0] vv;
         vv = WIDTH'(v);
         case (mode)
            0:       begin tab0[v] = vv[0]; tab1[v] = vv[6]; end
            1:       begin tab0[v] = 1'b1;  tab1[v] = 1'b1;  end
            default: begin tab0[v] = 1'($urandom); tab1[v] = 1'($urandom); end
         endcase
      end
   endtask

   task automatic check_all(input string tag, input int v, input int b, input int d,
                            input int c0, input int c1);
      check_val({tag, "_vec"},  32'(bus.vec),  32'(v));
      check_val({tag, "_busy"}, 32'(bus.busy), 32'(b));
      check_val({tag, "_done"}, 32'(bus.done), 32'(d));
      check_val({tag, "_cnt0"}, 32'(bus.cnt0), 32'(c0));
      check_val({tag, "_cnt1"}, 32'(bus.cnt1), 32'(c1));
   endtask

   // Runs one sweep. t counts cycles after the edge was taken: cycle t holds
   // vector t/PER and is the sample cycle when t%PER == PER-1. Negative
   // abort_t/restart_t/reset_t disable that event.
   task automatic run_sweep(input string tag, input bit noise, input int abort_t,
                            input int restart_t, input int reset_t);
      int e0 = 0;
      int e1 = 0;
      bus.start     = 1'b0;
      bus.manual_en = 1'b0;
      tick;
      bus.start = 1'b1;
      tick;
      check_all({tag, "_go"}, 0, 1, 0, 0, 0);
      for (int t = 0; t < NCYC; t++) begin
         int v;
         bit samp;
         v    = t / PER;
         samp = (t % PER) == (PER - 1);
         if (t == 1) bus.start = 1'($urandom);   // holding start longer is harmless
         if (t == 2) bus.start = 1'b0;
         if (t == restart_t)     bus.start = 1'b1;
         if (t == restart_t + 1) bus.start = 1'b0;
         bus.manual_en = 1'($urandom);
         bus.sw        = WIDTH'($urandom);
         if (noise && !samp) bus.res = 2'($urandom);
         else                bus.res = {tab1[v], tab0[v]};
         if (samp) begin
            check_val({tag, "_svec"},  32'(bus.vec),  32'(v));
            check_val({tag, "_sbusy"}, 32'(bus.busy), 32'd1);
         end
         if (t == abort_t) begin
            bus.manual_en = 1'b0;
            bus.abort     = 1'b1;
            tick;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            check_all({tag, "_abort"}, 0, 0, 0, e0, e1);
            return;
         end
         if (t == reset_t) begin
            check_val({tag, "_prerst_vec"}, 32'(bus.vec), 32'(v));
            #3 reset = 1'b1;
            bus.start = 1'b0;
            #1;
            check_all({tag, "_rst"}, 0, 0, 0, 0, 0);
            #1 reset = 1'b0;
            return;
         end
         if (samp) begin
            e0 += int'(tab0[v]);
            e1 += int'(tab1[v]);
         end
         tick;
      end
      bus.manual_en = 1'b0;
      check_all({tag, "_end"}, NVEC - 1, 0, 1, e0, e1);
   endtask

   task automatic manual_step(input string tag, input logic [WIDTH-1:0] s);
      bus.manual_en = 1'b1;
      bus.sw        = s;
      tick;
      check_val({tag, "_man"}, 32'(bus.vec), 32'(s));
   endtask

   task automatic hold_step(input string tag);
      logic [WIDTH-1:0] prev;
      prev          = bus.vec;
      bus.manual_en = 1'b0;
      bus.sw        = ~prev;
      tick;
      check_val({tag, "_hold"}, 32'(bus.vec), 32'(prev));
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.manual_en = 1'b0;
      bus.sw        = '0;
      bus.res       = '0;
      tick;
      tick;
      check_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick;
      check_all("post_reset", 0, 0, 0, 0, 0);

      // Manual mode from IDLE
      manual_step("idle_5a", 7'h5A);
      manual_step("idle_25", 7'h25);
      for (int i = 0; i < 4; i++) manual_step("idle_rnd", WIDTH'($urandom));
      hold_step("idle");

      // Full sweeps: fixed chain, stuck-high outputs, random tables with noise
      fill_tables(0);
      run_sweep("t1", 1'b0, -1, -1, -1);
      manual_step("done_man", WIDTH'($urandom));
      check_val("done_man_done", 32'(bus.done), 32'd1);
      hold_step("done");

      fill_tables(1);
      run_sweep("t2", 1'b0, -1, -1, -1);

      fill_tables(2);
      run_sweep("rnd_noise", 1'b1, -1, -1, -1);

      // Abort while vector 5 is settling, then at random points
      fill_tables(0);
      run_sweep("t4", 1'b0, 5 * PER, -1, -1);
      manual_step("abort_man", WIDTH'($urandom));
      for (int i = 0; i < 3; i++) begin
         fill_tables(2);
         run_sweep("abort_rnd", 1'b1, int'($urandom_range(0, NCYC - 1)), -1, -1);
      end

      // Restart request mid-sweep is ignored
      fill_tables(0);
      run_sweep("t5", 1'b0, -1, 100, -1);
      fill_tables(2);
      run_sweep("restart_rnd", 1'b1, -1, int'($urandom_range(3, NCYC - 2)), -1);

      // Asynchronous reset while vector 0x40 is applied, then a clean sweep
      fill_tables(0);
      run_sweep("t6", 1'b0, -1, -1, 8'h40 * PER);
      run_sweep("t6_clean", 1'b0, -1, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
